// File: rtl/synth_pkg.sv
// Shared constants for the synth peripheral blocks: register map offsets
// and the PWM bank defaults.
package synth_pkg;

    localparam int PWM_REG_DUTY0 = 0;
    localparam int PWM_REG_MASK  = 8;
    localparam int PWM_REG_CTRL  = 9;

    localparam logic [9:0] PWM_BASE_ADDR    = 10'h3F0;
    localparam int         PWM_DEFAULT_BITS = 8;
    // The register window covers 16 words, so 4 address bits select the register.
    localparam int         PWM_WINDOW_BITS  = 4;

endpackage

// File: rtl/synth_pwm_chan.sv
// One PWM channel: shadow/active duty pair, phase-offset comparator and
// registered output.
module synth_pwm_chan
    import synth_pkg::*;
#(
    parameter int PWM_BITS = PWM_DEFAULT_BITS,
    parameter int PHASE    = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                duty_we,
    input  logic [PWM_BITS-1:0] duty_wdata,
    input  logic                load,
    input  logic                enable,
    input  logic                mask,
    input  logic [PWM_BITS-1:0] cnt,
    output logic                pwm
);

    logic [PWM_BITS-1:0] duty_shadow;
    logic [PWM_BITS-1:0] duty_active;
    logic [PWM_BITS-1:0] phase_cnt;

    // Truncation to PWM_BITS gives the modulo-period wrap for free.
    assign phase_cnt = cnt + PWM_BITS'(PHASE);

    // NOTE: non-blocking assignments make every right-hand side read the
    // pre-edge value, which is what lets a write and a load share one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_shadow <= '0;
            duty_active <= '0;
            pwm         <= 1'b0;
        end else begin
            if (load) begin
                duty_active <= duty_shadow;
            end
            if (duty_we) begin
                duty_shadow <= duty_wdata;
            end
            pwm <= enable & mask & (phase_cnt < duty_active);
        end
    end

endmodule

// File: rtl/synth_pwm_bank.sv
// Memory-mapped PWM audio bank that snoops the core write bus. Optional
// phase staggering of channel carriers: SYNTH_PWM_PHASE_STAGGER_EN.
module synth_pwm_bank
    import synth_pkg::*;
#(
    parameter int                NUM_CH    = 8,
    parameter int                ADDR_W    = 10,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(PWM_BASE_ADDR),
    parameter int                PWM_BITS  = PWM_DEFAULT_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick,
    output logic              enabled
);

    localparam int                  WIN_W   = PWM_WINDOW_BITS;
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

`ifdef SYNTH_PWM_PHASE_STAGGER_EN
    localparam int PHASE_STEP = (1 << PWM_BITS) / NUM_CH;
`else
    localparam int PHASE_STEP = 0;
`endif

    logic                in_window;
    logic [WIN_W-1:0]    offset;
    logic [NUM_CH-1:0]   duty_we;
    logic                mask_we;
    logic                ctrl_we;
    logic                enable;
    logic                load;
    logic [PWM_BITS-1:0] cnt;
    logic [NUM_CH-1:0]   mask_shadow;
    logic [NUM_CH-1:0]   mask_active;
    logic                unused_data_bits;

    assign in_window = wr_en && (wr_addr[ADDR_W-1:WIN_W] == BASE_ADDR[ADDR_W-1:WIN_W]);
    assign offset    = wr_addr[WIN_W-1:0];

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        duty_we = '0;
        mask_we = 1'b0;
        ctrl_we = 1'b0;
        if (in_window) begin
            if (offset == WIN_W'(PWM_REG_MASK)) begin
                mask_we = 1'b1;
            end else if (offset == WIN_W'(PWM_REG_CTRL)) begin
                ctrl_we = 1'b1;
            end else begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (offset == WIN_W'(PWM_REG_DUTY0 + k)) begin
                        duty_we[k] = 1'b1;
                    end
                end
            end
        end
    end

    // While disabled the active registers track the shadows every cycle.
    assign load        = enable ? (cnt == CNT_MAX) : 1'b1;
    assign period_tick = enable && (cnt == CNT_MAX);
    assign enabled     = enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable      <= 1'b0;
            cnt         <= '0;
            mask_shadow <= '0;
            mask_active <= '0;
        end else begin
            if (ctrl_we) begin
                enable <= wr_data[0];
            end
            cnt <= enable ? cnt + 1'b1 : '0;
            if (load) begin
                mask_active <= mask_shadow;
            end
            if (mask_we) begin
                mask_shadow <= wr_data[NUM_CH-1:0];
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        synth_pwm_chan #(
            .PWM_BITS (PWM_BITS),
            .PHASE    (k * PHASE_STEP)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .duty_we    (duty_we[k]),
            .duty_wdata (wr_data[PWM_BITS-1:0]),
            .load       (load),
            .enable     (enable),
            .mask       (mask_active[k]),
            .cnt        (cnt),
            .pwm        (pwm_out[k])
        );
    end

    // Upper data bits carry nothing for this block.
    assign unused_data_bits = ^wr_data[DATA_W-1:PWM_BITS];

endmodule

// File: tb/tb_synth_pwm_bank.sv
// Self-checking bench for synth_pwm_bank: register-write vector table,
// directed boundary sequences and random bus traffic against a model.
module tb_synth_pwm_bank;

    localparam int         NUM_CH = 8;
    localparam int         PERIOD = 256;
    localparam logic [9:0] BASE   = 10'h3F0;
`ifdef SYNTH_PWM_PHASE_STAGGER_EN
    localparam int STEP = PERIOD / NUM_CH;
`else
    localparam int STEP = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [9:0]        wr_addr;
    logic [15:0]       wr_data;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_tick;
    logic              enabled;

    always #5 clk = ~clk;

    synth_pwm_bank dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .enabled     (enabled)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: register contents and position within the PWM period.
    int          m_sduty [NUM_CH];
    int          m_aduty [NUM_CH];
    logic [7:0]  m_smask;
    logic [7:0]  m_amask;
    bit          m_en;
    int          m_cnt;
    logic [7:0]  m_pwm;

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_sduty[k] = 0;
            m_aduty[k] = 0;
        end
        m_smask = '0;
        m_amask = '0;
        m_en    = 1'b0;
        m_cnt   = 0;
        m_pwm   = '0;
    endtask

    task automatic model_step(input bit we, input logic [9:0] a, input logic [15:0] d);
        bit         new_en;
        logic [7:0] new_pwm;
        int         off;
        new_en = m_en;
        for (int k = 0; k < NUM_CH; k++) begin
            new_pwm[k] = m_en && m_amask[k] && (((m_cnt + k * STEP) % PERIOD) < m_aduty[k]);
        end
        if (!m_en || m_cnt == PERIOD - 1) begin
            for (int k = 0; k < NUM_CH; k++) m_aduty[k] = m_sduty[k];
            m_amask = m_smask;
        end
        if (we && a >= BASE && int'(a) <= int'(BASE) + 15) begin
            off = int'(a) - int'(BASE);
            if (off < NUM_CH) m_sduty[off] = int'(d[7:0]);
            else if (off == 8) m_smask = d[7:0];
            else if (off == 9) new_en = d[0];
        end
        m_cnt = m_en ? (m_cnt + 1) % PERIOD : 0;
        m_en  = new_en;
        m_pwm = new_pwm;
    endtask

    // Drive one bus cycle from a falling edge, then compare on the next falling edge.
    task automatic cycle(input bit we, input logic [9:0] a, input logic [15:0] d);
        wr_en   = we;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        model_step(we, a, d);
        @(negedge clk);
        wr_en = 1'b0;
        check("pwm_out", {24'd0, pwm_out}, {24'd0, m_pwm});
        check("period_tick", {31'd0, period_tick}, {31'd0, (m_en && m_cnt == PERIOD - 1)});
        check("enabled", {31'd0, enabled}, {31'd0, m_en});
    endtask

    task automatic idle();
        cycle(1'b0, 10'd0, 16'd0);
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        idle();
        while (period_tick !== 1'b1 && n < 600) begin
            idle();
            n++;
        end
        check(name, {31'd0, period_tick}, 32'd1);
    endtask

    int hi_cnt [NUM_CH];
    int tick_cnt;

    task automatic measure(input int n);
        for (int k = 0; k < NUM_CH; k++) hi_cnt[k] = 0;
        tick_cnt = 0;
        repeat (n) begin
            idle();
            for (int k = 0; k < NUM_CH; k++) hi_cnt[k] += int'(pwm_out[k]);
            tick_cnt += int'(period_tick);
        end
    endtask

    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] data;
        logic        en;
        logic [8:0]  hi0;
        logic [8:0]  hi1;
        logic [8:0]  hi2;
        logic [8:0]  hi3;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int n;
        int run;
        bit still;
        int sum;
        logic [9:0]  ra;
        logic [15:0] rd;

        vecs[0]  = '{BASE + 10'd0,  16'h0040, 1'b0, 9'd0,   9'd0, 9'd0,   9'd0};
        vecs[1]  = '{BASE + 10'd8,  16'h0001, 1'b0, 9'd0,   9'd0, 9'd0,   9'd0};
        vecs[2]  = '{BASE + 10'd9,  16'h0001, 1'b1, 9'd64,  9'd0, 9'd0,   9'd0};
        vecs[3]  = '{BASE + 10'd1,  16'h0000, 1'b1, 9'd64,  9'd0, 9'd0,   9'd0};
        vecs[4]  = '{BASE + 10'd2,  16'h00FF, 1'b1, 9'd64,  9'd0, 9'd0,   9'd0};
        vecs[5]  = '{BASE + 10'd8,  16'h0006, 1'b1, 9'd0,   9'd0, 9'd255, 9'd0};
        vecs[6]  = '{BASE + 10'd8,  16'h0007, 1'b1, 9'd64,  9'd0, 9'd255, 9'd0};
        vecs[7]  = '{BASE + 10'd10, 16'hFFFF, 1'b1, 9'd64,  9'd0, 9'd255, 9'd0};
        vecs[8]  = '{BASE + 10'd15, 16'hFFFF, 1'b1, 9'd64,  9'd0, 9'd255, 9'd0};
        vecs[9]  = '{BASE - 10'd1,  16'hFFFF, 1'b1, 9'd64,  9'd0, 9'd255, 9'd0};
        vecs[10] = '{BASE + 10'd3,  16'h1234, 1'b1, 9'd64,  9'd0, 9'd255, 9'd0};
        vecs[11] = '{BASE + 10'd8,  16'h000F, 1'b1, 9'd64,  9'd0, 9'd255, 9'd52};
        vecs[12] = '{BASE + 10'd0,  16'hFF80, 1'b1, 9'd128, 9'd0, 9'd255, 9'd52};
        vecs[13] = '{BASE + 10'd9,  16'hFFFE, 1'b0, 9'd0,   9'd0, 9'd0,   9'd0};
        vecs[14] = '{BASE + 10'd9,  16'h0001, 1'b1, 9'd128, 9'd0, 9'd255, 9'd52};

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        model_reset();
        #1;
        check("reset_pwm_out", {24'd0, pwm_out}, 32'd0);
        check("reset_period_tick", {31'd0, period_tick}, 32'd0);
        check("reset_enabled", {31'd0, enabled}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) idle();

        // Register-write table: each write is followed by a full-period count.
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, vecs[i].addr, vecs[i].data);
            if (vecs[i].en) begin
                wait_tick("vec_tick_a");
                wait_tick("vec_tick_b");
            end
            measure(PERIOD);
            check($sformatf("vec%0d_enabled", i), {31'd0, enabled}, {31'd0, vecs[i].en});
            check($sformatf("vec%0d_hi0", i), hi_cnt[0], {23'd0, vecs[i].hi0});
            check($sformatf("vec%0d_hi1", i), hi_cnt[1], {23'd0, vecs[i].hi1});
            check($sformatf("vec%0d_hi2", i), hi_cnt[2], {23'd0, vecs[i].hi2});
            check($sformatf("vec%0d_hi3", i), hi_cnt[3], {23'd0, vecs[i].hi3});
            check($sformatf("vec%0d_ticks", i), tick_cnt, vecs[i].en ? 32'd1 : 32'd0);
        end

        // Tick period, then a duty write landing exactly on the load edge.
        cycle(1'b1, BASE + 10'd8, 16'h0001);
        cycle(1'b1, BASE + 10'd0, 16'd64);
        wait_tick("a_tick_a");
        wait_tick("a_tick_b");
        n = 0;
        do begin
            idle();
            n++;
        end while (period_tick !== 1'b1 && n < 600);
        check("tick_period", n, PERIOD);
        cycle(1'b1, BASE + 10'd0, 16'd200);
        measure(PERIOD);
        check("coincident_write_old_period", hi_cnt[0], 64);
        measure(PERIOD);
        check("coincident_write_new_period", hi_cnt[0], 200);

        // Disable at cnt=30, then re-enable and look for a fresh 64-cycle run.
        cycle(1'b1, BASE + 10'd0, 16'd64);
        wait_tick("b_tick_a");
        wait_tick("b_tick_b");
        wait_tick("b_tick_c");
        repeat (31) idle();
        cycle(1'b1, BASE + 10'd9, 16'd0);
        check("pwm0_at_disable_edge", {31'd0, pwm_out[0]}, 32'd1);
        idle();
        check("pwm0_after_disable", {31'd0, pwm_out[0]}, 32'd0);
        check("enabled_after_disable", {31'd0, enabled}, 32'd0);
        measure(20);
        check("disabled_hi0", hi_cnt[0], 0);
        check("disabled_ticks", tick_cnt, 0);
        cycle(1'b1, BASE + 10'd9, 16'd1);
        check("pwm0_at_enable_edge", {31'd0, pwm_out[0]}, 32'd0);
        run = 0;
        still = 1'b1;
        sum = 0;
        for (int i = 0; i < 70; i++) begin
            idle();
            if (pwm_out[0] && still) run++;
            else still = 1'b0;
            sum += int'(pwm_out[0]);
        end
        check("reenable_first_run", run, 64);
        check("reenable_hi_total", sum, 64);

        // Random bus traffic, mostly inside the window, checked every cycle.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 4) == 0) ra = 10'($urandom);
                else ra = BASE + 10'($urandom_range(0, 15));
                rd = 16'($urandom);
                if (ra == BASE + 10'd9) rd[0] = ($urandom_range(0, 4) != 0);
                cycle(1'b1, ra, rd);
            end else begin
                idle();
            end
        end

        // Asynchronous reset in the middle of a running high phase.
        cycle(1'b1, BASE + 10'd9, 16'd1);
        cycle(1'b1, BASE + 10'd8, 16'h0001);
        cycle(1'b1, BASE + 10'd0, 16'd128);
        wait_tick("c_tick_a");
        wait_tick("c_tick_b");
        wait_tick("c_tick_c");
        repeat (10) idle();
        check("pwm0_before_reset", {31'd0, pwm_out[0]}, 32'd1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("midcycle_reset_pwm_out", {24'd0, pwm_out}, 32'd0);
        check("midcycle_reset_tick", {31'd0, period_tick}, 32'd0);
        check("midcycle_reset_enabled", {31'd0, enabled}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        measure(300);
        sum = 0;
        for (int k = 0; k < NUM_CH; k++) sum += hi_cnt[k];
        check("after_reset_hi_total", sum, 0);
        check("after_reset_ticks", tick_cnt, 0);
        cycle(1'b1, BASE + 10'd8, 16'h00FF);
        cycle(1'b1, BASE + 10'd9, 16'd1);
        wait_tick("c_tick_d");
        wait_tick("c_tick_e");
        measure(PERIOD);
        sum = 0;
        for (int k = 0; k < NUM_CH; k++) sum += hi_cnt[k];
        check("after_reset_duties_cleared", sum, 0);
        check("after_reset_tick_resumes", tick_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
